// File: rtl/enc_quad_gen.sv
// Quadrature encoder signal generator.
// Emits A/B quadrature edges spaced max(period_in,2) clocks apart, in the
// selected direction, for a counted run or continuously until stop.
module enc_quad_gen #(
  parameter int PW = 22,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [PW-1:0] period_in,
  input  logic          dir_in,
  input  logic [CW-1:0] num_edges,
  output logic          a,
  output logic          b,
  output logic          tick,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] edge_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] timer;
  logic [1:0]    phase;
  logic [CW-1:0] num_lat;

  logic [PW-1:0] p_eff;
  logic [1:0]    phase_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          last_edge;

  // Gray-style phase to {a,b}: 00 -> 10 -> 11 -> 01, one bit flips per step.
  function automatic logic [1:0] ab_map(input logic [1:0] ph);
    case (ph)
      2'd0:    ab_map = 2'b00;
      2'd1:    ab_map = 2'b10;
      2'd2:    ab_map = 2'b11;
      default: ab_map = 2'b01;
    endcase
  endfunction

  // Periods below 2 would collapse edges together, so clamp to 2.
  assign p_eff     = (period_in < PW'(2)) ? PW'(2) : period_in;
  assign phase_nxt = dir_in ? phase - 2'd1 : phase + 2'd1;
  assign cnt_nxt   = edge_count + CW'(1);
  assign last_edge = (num_lat != '0) && (cnt_nxt == num_lat);

  // Run control, edge timer and registered A/B/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      phase      <= 2'd0;
      num_lat    <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= '0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Phase is kept so a new run continues from the current levels.
          if (start && !stop) begin
            state      <= RUN;
            busy       <= 1'b1;
            timer      <= p_eff;
            edge_count <= '0;
            num_lat    <= num_edges;
          end
        end
        RUN: begin
          if (stop) begin
            // Stop beats a coincident timer expiry: no edge, levels hold.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer == PW'(1)) begin
            phase      <= phase_nxt;
            {a, b}     <= ab_map(phase_nxt);
            tick       <= 1'b1;
            edge_count <= cnt_nxt;
            timer      <= p_eff;
            if (last_edge) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - PW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/enc_quad_gen.md
# enc_quad_gen

Quadrature encoder signal generator: produces A/B channels with a programmable edge-to-edge period, direction and edge count. It is the transmitting end of the encoder path. Its `a`/`b` outputs drive the encoder quadrature decode and period-measurement logic directly, or through test I/O, for closed-loop firmware self-test and velocity-estimation verification. It runs on the system clock.

## Interface
- `PW`, 22: width of period register (matches period-measurement counter width)
- `CW`, 16: width of edge-count registers
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a run; honoured only in IDLE
- `stop`  in  1  one-cycle request to abort a run
- `period_in`  in  PW  clk cycles between successive quadrature edges (P)
- `dir_in`  in  1  0: A leads B (Aup→Bup→Adn→Bdn); 1: B leads A (Bup→Aup→Bdn→Adn)
- `num_edges`  in  CW  edges to emit in the run; 0 = continuous until `stop`
- `a`  out  1  quadrature channel A (registered)
- `b`  out  1  quadrature channel B (registered)
- `tick`  out  1  one-cycle pulse coincident with every A/B transition
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse coincident with the final edge of a counted run
- `edge_count`  out  CW  edges emitted since last accepted start

## Operation
- Reset values: `a`=0, `b`=0, phase=0, `tick`=0, `busy`=0, `done`=0, `edge_count`=0, timer=0, state IDLE.
- Phase register (2 bits) maps to {a,b}: 0→00, 1→10, 2→11, 3→01. dir 0 increments phase mod 4; dir 1 decrements mod 4. Only one of A/B changes per edge.
- States: IDLE, RUN.
- IDLE→RUN on `start`=1 and `stop`=0:
  - timer loads P_eff, where P_eff = max(period_in, 2).
  - `edge_count` clears and `num_edges` is latched.
  - Phase is NOT reset, so a new run continues from the current A/B levels.
- RUN: timer decrements every cycle. On the cycle it reaches 1:
  - Phase advances per `dir_in` sampled that cycle. Direction reversal takes effect at the next edge.
  - `tick`=1 and `edge_count`+1, wrapping mod 2^CW.
  - Timer reloads max(period_in, 2) sampled that cycle. Period may change per edge.
- Counted run (latched num_edges ≠ 0): when `edge_count` reaches num_edges, `done`=1 with that `tick` and the state returns to IDLE.
- `stop` in RUN → IDLE on the next edge:
  - No further ticks and no `done`.
  - `a`/`b` hold their current levels.
  - `edge_count` holds.
- `stop` in IDLE: no effect. `start` and `stop` in the same cycle: `stop` wins. `start` while in RUN is ignored.
- Timer expiry coincident with `stop`: `stop` wins; the edge is not emitted.
- `busy` = (state == RUN), registered.

## Timing
- Start accepted on edge T0. Edge k appears on `a`/`b` (and `tick`) at edge T0 + Σ P_i, for i=1..k. Constant P gives T0 + k·P.
- Minimum edge spacing is 2 cycles, because P of 0 or 1 is clamped to 2.
- `busy` rises at T0 and falls on the edge that emits the final tick of a counted run, the same edge as `done`. After `stop`, it falls one clock later.
- A new `start` is accepted in the first cycle that `busy`=0.
- Asynchronous reset mid-run forces all reset values immediately. The first edge after reset release is to phase 1 (dir 0) or phase 3 (dir 1).

## Test plan
- Reset, then start with P=5, dir=0, num_edges=8: {a,b} goes 10,11,01,00,10,11,01,00 at cycles 5,10,…,40. `tick` appears at each edge. `done`+`busy`↓ at cycle 40; `edge_count`=8.
- P=4, dir=1, num_edges=4 from phase 0: {a,b} goes 01,11,10,00 at cycles 4,8,12,16. Each edge changes exactly one bit.
- Continuous run (num_edges=0, P=3), dir flipped 0→1 after edge 6: edge 7 reverses phase (phase 2→1). Edges stay 3 cycles apart. `stop` at cycle 30 gives no further ticks, `a`/`b` hold, and `done` never asserts.
- period_in=0 and 1: edges spaced 2 cycles. period_in changed 10→3 mid-run: the new spacing applies starting with the interval after the next emitted edge.
- `start`+`stop` in the same cycle: stays IDLE. `start` during RUN: ignored, `edge_count` not cleared. Counter wrap: num_edges=0 past 65535 edges → `edge_count` wraps to 0.
- Loopback into the period-measurement block: P=100 at dir 0 gives measured period 100 ±1 per edge. A reversal sets the receiver's direction-changed flag.
